// File: rtl/bam_mul_scheduler.sv
// rtl/bam_mul_scheduler.sv - round-robin scheduler sharing one 8x8 BAM (h=0, v=10) multiplier.
// Optional BAM_SCHED_EXACT_EN adds per-request req_exact selecting the full a*b product.
module bam_mul_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
`ifdef BAM_SCHED_EXACT_EN
  input  logic [NREQ-1:0]   req_exact,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_p
);

  logic           op_v;
  logic [7:0]     op_a;
  logic [7:0]     op_b;
  logic [IDW-1:0] op_id;
  logic           op_x;
  logic [IDW-1:0] ptr;

  logic           res_ld;
  logic           op_free;
  logic           found;
  logic           hs;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic [7:0]     sel_a;
  logic [7:0]     sel_b;
  logic           sel_x;
  logic [15:0]    bam_p;
  logic [15:0]    prod;

  assign res_ld  = op_v & (~rsp_valid | rsp_ready);
  assign op_free = ~op_v | res_ld;
  assign hs      = found & op_free & ~rst;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[win] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_x = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IDW'(k)) begin
        sel_a = req_a[8*k +: 8];
        sel_b = req_b[8*k +: 8];
`ifdef BAM_SCHED_EXACT_EN
        sel_x = req_exact[k];
`endif
      end
    end
  end

  // Broken array: partial products in columns below 10 are never generated.
  always_comb begin
    bam_p = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if ((i + j) >= 10 && op_a[i] && op_b[j]) bam_p = bam_p + (16'd1 << (i + j));
      end
    end
  end

`ifdef BAM_SCHED_EXACT_EN
  assign prod = op_x ? ({8'd0, op_a} * {8'd0, op_b}) : bam_p;
`else
  assign prod = bam_p;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_v      <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      op_x      <= 1'b0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      if (hs) begin
        op_v  <= 1'b1;
        op_a  <= sel_a;
        op_b  <= sel_b;
        op_id <= win;
        op_x  <= sel_x;
        ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end else if (res_ld) begin
        op_v <= 1'b0;
      end
      if (res_ld) begin
        rsp_valid <= 1'b1;
        rsp_p     <= prod;
        rsp_id    <= op_id;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bam_mul_scheduler.sv
// tb/tb_bam_mul_scheduler.sv - scoreboard bench for bam_mul_scheduler (directed steps plus random stress).
module tb_bam_mul_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
`ifdef BAM_SCHED_EXACT_EN
  logic [NREQ-1:0]   req_exact;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_p;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    p;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bam_mul_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef BAM_SCHED_EXACT_EN
    .req_exact (req_exact),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  // Reference: full product minus every partial product in columns 0..9.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic x);
    int full;
    int low;
    full = int'(a) * int'(b);
    if (x) return 16'(full);
    low = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if ((i + j) < 10 && a[i] && b[j]) low += (1 << (i + j));
    return 16'(full - low);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic single(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep, input string tag);
    set_req(i, a, b);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    chk({tag, "_lat"}, 32'(rsp_valid), 0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_p"}, 32'(rsp_p), 32'(ep));
    chk({tag, "_id"}, 32'(rsp_id), 32'(i));
    tick();
  endtask

  // Scoreboard: push on handshake, pop on response consume; reset discards all in-flight work.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL rsp_unexpected observed_id=%0d observed_p=%0d expected=none", rsp_id, rsp_p);
        end
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
          chk("sb_rsp_p", 32'(rsp_p), 32'(e.p));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
`ifdef BAM_SCHED_EXACT_EN
          exp_q.push_back({IDW'(i), ref_prod(req_a[8*i +: 8], req_b[8*i +: 8], req_exact[i])});
`else
          exp_q.push_back({IDW'(i), ref_prod(req_a[8*i +: 8], req_b[8*i +: 8], 1'b0)});
`endif
        end
      end
    end
  end

  initial begin
    int          hs_cnt;
    logic [15:0] keep_p;
    logic [IDW-1:0] keep_id;
    int          accepted;
    int          cyc;
    logic [NREQ-1:0] hm;

    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef BAM_SCHED_EXACT_EN
    req_exact = '0;
`endif
    keep_p  = '0;
    keep_id = '0;
    tick();
    tick();
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_p", 32'(rsp_p), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    single(2, 8'd255, 8'd255, 16'd58368, "max");
`ifdef BAM_SCHED_EXACT_EN
    req_exact[2] = 1'b1;
    single(2, 8'd255, 8'd255, 16'd65025, "max_exact");
    req_exact[2] = 1'b0;
`endif
    single(3, 8'd128, 8'd8, 16'd1024, "col_hi");
    single(3, 8'd3, 8'd3, 16'd0, "col_lo");
    single(3, 8'd8, 8'd128, 16'd1024, "col_sym");

    // Fairness: all requesters valid, pointer starts at 0.
    for (int w = 0; w < NREQ; w++) set_req(w, 8'(37 * w + 200), 8'(11 * w + 131));
    for (int n = 0; n < 8; n++) begin
      #1;
      chk("fair_grant", 32'(req_ready), 32'(1 << (n % 4)));
      @(posedge clk);
      #1;
      if (n >= 1) begin
        chk("fair_rsp_valid", 32'(rsp_valid), 1);
        chk("fair_rsp_id", 32'(rsp_id), 32'((n - 1) % 4));
      end
      req_a[8*(n % 4) +: 8] = 8'(13 * n + 60);
      req_b[8*(n % 4) +: 8] = 8'(29 * n + 170);
    end
    req_valid = '0;
    tick();
    chk("fair_last_valid", 32'(rsp_valid), 1);
    chk("fair_last_id", 32'(rsp_id), 3);
    tick();

    // Backpressure with requesters 0 and 1.
    rsp_ready = 1'b0;
    set_req(0, 8'd240, 8'd200);
    set_req(1, 8'd199, 8'd251);
    hs_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      hs_cnt += $countones(req_valid & req_ready);
      if (c == 2) begin
        keep_p  = rsp_p;
        keep_id = rsp_id;
      end
      if (c >= 3) begin
        chk("bp_stable_p", 32'(rsp_p), 32'(keep_p));
        chk("bp_stable_id", 32'(rsp_id), 32'(keep_id));
      end
      @(posedge clk);
      #1;
    end
    #1;
    chk("bp_handshakes", 32'(hs_cnt), 2);
    chk("bp_ready_low", 32'(req_ready), 0);
    chk("bp_rsp_id0", 32'(rsp_id), 0);
    chk("bp_rsp_p0", 32'(rsp_p), 32'(ref_prod(8'd240, 8'd200, 1'b0)));
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    chk("bp_order_id1", 32'(rsp_id), 1);
    tick();
    tick();
    tick();

    // Reset while both registers hold work; pointer is at 2 beforehand.
    rsp_ready = 1'b0;
    set_req(0, 8'd222, 8'd111);
    set_req(1, 8'd177, 8'd233);
    tick();
    tick();
    chk("rst_full_valid", 32'(rsp_valid), 1);
    req_valid = 4'b1001;
    req_a[8*3 +: 8] = 8'd250;
    req_b[8*3 +: 8] = 8'd66;
    rst = 1'b1;
    #1;
    chk("rst_ready_low", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_lowest_grant", 32'(req_ready), 32'(4'b0001));
    rsp_ready = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // Random stress.
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 60000) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 8'($urandom), 8'($urandom));
`ifdef BAM_SCHED_EXACT_EN
          req_exact[i] = 1'($urandom_range(0, 1));
`endif
        end
      end
      @(negedge clk);
      hm = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hm;
      accepted += $countones(hm);
      cyc++;
    end
    chk("stress_accepted", 32'(accepted), 10000);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("drained_valid", 32'(rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bam_mul_scheduler.md
# bam_mul_scheduler

Round-robin scheduler that shares one 8x8 unsigned broken-array multiplier (BAM, h=0, v=10) among NREQ requesters. Operands are accepted over per-requester valid/ready handshakes and pushed through a two-register pipeline: an operand register followed by a result register. Products return on one response channel tagged with the requester index. The block sits between lightweight approximate-compute clients and the flat generated multiplier datapath.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, $clog2(NREQ): width of the response ID.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  bit i: requester i presents an operand pair.
- req_ready  output  NREQ  bit i: requester i's pair is accepted this cycle. At most one bit is high.
- req_a  input  NREQ*8  operand a of requester i at bits [8i+7:8i].
- req_b  input  NREQ*8  operand b of requester i at bits [8i+7:8i].
- req_exact  input  NREQ  per-request exact-mode select. Present only with BAM_SCHED_EXACT_EN.
- rsp_valid  output  1  result register holds a product.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that issued the product.
- rsp_p  output  16  product.

## Operation
- Approximate product: rsp_p = sum over i,j in 0..7 with i+j>=10 of a[i]&b[j] << (i+j). All columns below 10 are zero. Upper columns are summed with full carry propagation, so the result is exact modulo the dropped terms and fits in 16 bits.
- Operand register: op_v, op_a, op_b, op_id (and op_x when the macro is defined).
- Result register: rsp_valid, rsp_p, rsp_id.
- Advance conditions:
  - res_ld = op_v & (~rsp_valid | rsp_ready).
  - op_free = ~op_v | res_ld.
- Arbiter:
  - Pointer ptr is reset to 0.
  - The winner is the first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[winner] = op_free. All other ready bits are 0. With no valid requests, all ready bits are 0.
  - On a handshake (req_valid[i] & req_ready[i]): op register loads the pair, op_v=1, and ptr=(i+1) mod NREQ.
  - With no handshake, ptr holds.
- On res_ld: the result register loads the product computed from the op register, and rsp_valid=1.
- Without res_ld: if rsp_valid & rsp_ready, rsp_valid=0. Otherwise the result holds stable.
- If the op register is not refilled while res_ld occurs, op_v=0.
- req_ready depends combinationally on req_valid. A requester must not wait for ready before asserting valid.
- A requester holds a, b and valid stable until its handshake.
- Reset:
  - req_ready=0, rsp_valid=0, rsp_p=0, rsp_id=0.
  - op_v=0, ptr=0.
  - In-flight operations are discarded, with no response.
- Simultaneous accept and drain: a new grant, op->result transfer, and result consume may all occur in the same cycle. No bubble is inserted.

## Timing
- Latency: a handshake on edge k gives rsp_valid=1 after edge k+1, i.e. result visible in the cycle after the op-register load cycle (2 edges after the request cycle).
- Throughput: 1 product per cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0 and both registers full, every req_ready is 0 until the consumer drains.
- The multiplier datapath is combinational between the two registers. There is no internal state beyond ptr, op register and result register.

## Configuration
- BAM_SCHED_EXACT_EN defined:
  - Adds req_exact.
  - op_x is latched with the operands.
  - When op_x=1 the result register loads the full a*b instead of the BAM product.
  - Arbitration and timing are unchanged.
- Not defined: the req_exact port is absent, and every product is the BAM h0 v10 product.

## Test plan
- Single request, requester 2 sends a=255, b=255, rsp_ready=1:
  - required: rsp_valid two edges after the handshake, rsp_p=58368, rsp_id=2.
  - with macro and req_exact=1: rsp_p=65025.
- Column boundary:
  - a=128, b=8: rsp_p=1024.
  - a=3, b=3: rsp_p=0.
  - a=8, b=128: rsp_p=1024.
- Fairness: all 4 requesters hold valid for 8 cycles with rsp_ready=1 and distinct operands. Required: grants go in order 0,1,2,3,0,1,2,3, and rsp_id follows the same sequence with no gaps.
- Backpressure: rsp_ready=0 for 5 cycles with requesters 0 and 1 valid. Required:
  - exactly 2 handshakes, then all req_ready=0;
  - rsp_p and rsp_id stable throughout;
  - after rsp_ready=1, both results emerge in order with no loss or duplication.
- Reset mid-operation: assert rst for one cycle while both registers are full. Required:
  - next cycle rsp_valid=0, ptr=0;
  - the discarded ops never appear on the response channel;
  - the next grant goes to the lowest valid index.
- Random stress: 10k random requests with random rsp_ready. Compare every response against the reference sum over i+j>=10 (or the exact product when req_exact=1), tracked per requester in order.
